fir_coeff_wb_loader: RTL and testbench
======================================

# fir_coeff_wb_loader

Wishbone initiator that streams FIR coefficients into the FIR register file. Accepts 16-bit coefficients on a valid/ready input and issues one 16-bit Wishbone write per coefficient to consecutive addresses from a programmable base. With readback verify compiled in, it reads each register back and flags mismatches. It sits between the DMA/control path and the FIR coefficient register slave.

## Interface
Parameters:
- ACK_TIMEOUT, 15: cycles a read strobe may wait for wb_ack before aborting (1..255).
- MAX_COUNT, 34: largest legal burst length (coefficients 0..32 plus test-vector select).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; launches a load
- base_adr  in  8  first Wishbone address, sampled on start
- count  in  6  number of coefficients, sampled on start
- s_coef_data  in  16  coefficient value
- s_coef_valid  in  1  coefficient available
- s_coef_ready  out  1  loader accepts coefficient
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load end (success or failure)
- error  out  1  sticky failure flag, cleared by next accepted start
- err_index  out  6  index of the failing coefficient
- wb_adr  out  8  address
- wb_rd_dat  in  16  read data
- wb_wr_dat  out  16  write data
- wb_we  out  1  1 = write
- wb_sel  out  2  byte selects, always 2'b11 during a cycle
- wb_stb  out  1  strobe
- wb_ack  in  1  acknowledge
- wb_err  in  1  slave error
- wb_cyc  out  1  bus cycle

## Operation
- States: IDLE, FETCH, WRITE, RD_REQ, CHECK, FINISH.
- IDLE: start=1 latches base_adr, count; clears error, err_index, index; count=0 → FINISH directly (no bus activity); count>MAX_COUNT → error=1, err_index=0, FINISH. Otherwise → FETCH. start outside IDLE is ignored.
- FETCH: s_coef_ready=1; on valid&ready latch data → WRITE. s_coef_ready=0 in every other state.
- WRITE: posted write, one cycle: wb_cyc=wb_stb=wb_we=1, wb_sel=2'b11, wb_adr=base+index (8-bit wrap, 0xFF+1=0x00), wb_wr_dat=latched coefficient. No ack awaited. Next: RD_REQ if verify built in, else index+1 → FETCH, or FINISH after last.
- RD_REQ: wb_cyc=wb_stb=1, wb_we=0, same address; hold until wb_ack or wb_err or timeout counter reaches ACK_TIMEOUT. On ack capture wb_rd_dat → CHECK. wb_err or timeout → error=1, err_index=index, FINISH.
- CHECK: mismatch → error=1, err_index=index, FINISH; match → next coefficient or FINISH.
- FINISH: done=1 one cycle → IDLE. busy=1 in all states except IDLE.
- wb_ack/wb_err outside RD_REQ are ignored.
- Remaining stream data after an abort is not consumed.

## Timing
- Reset values: s_coef_ready, busy, done, error, wb_cyc, wb_stb, wb_we=0; err_index, wb_adr, wb_wr_dat=0; wb_sel=2'b00; state IDLE.
- All outputs registered; wb_stb/wb_cyc deasserted the cycle after ack is sampled; never asserted in IDLE or FINISH.
- Without verify: 2 cycles per coefficient with valid held high; start-to-done = 1 + 2·count + 1 cycles.
- With verify and a slave acking one cycle after strobe: 5 cycles per coefficient.
- rst mid-load: returns to IDLE next edge, bus released immediately, partial writes are not undone.

## Configuration
- FIR_LOADER_VERIFY_EN defined: RD_REQ/CHECK, timeout counter and compare logic built; ACK_TIMEOUT used.
- Undefined: write-only; RD_REQ/CHECK unreachable and removed, error only from count>MAX_COUNT, wb_rd_dat/wb_ack/wb_err unused.

## Structure
- Shared package fir_pkg: state enum, FIR_NUM_COEF=33, FIR_TESTVEC_ADR=8'h1E, WB address/data widths.
- One sub-module natural: fir_wb_rd_timeout (loadable down-counter, expiry flag).
- FSM, address counter and datapath in the top module.

## Test plan
- start, base=0x00, count=3, data 0x0001/0x0002/0xFFFF (valid held) → writes to 0x00,0x01,0x02 with sel=2'b11; done after 8 cycles (no verify).
- Verify on, register slave model, count=33, data=index·0x0101 → all readbacks match, error=0, done once.
- Verify on, slave corrupts address 0x05 readback to 0x1234 → error=1, err_index=5, done pulse, no access to 0x06.
- Verify on, slave never acks, ACK_TIMEOUT=15 → strobe held 15 cycles, then error=1, err_index=0, wb_cyc=0.
- count=0 → done one cycle after start, no wb_stb; count=40 → error=1, done, no bus cycles.
- base=0xFE, count=3, valid toggling every other cycle, rst asserted after second write → addresses 0xFE,0xFF, then bus idle, busy=0 one cycle after rst.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient Wishbone loader.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_RD_REQ,
        ST_CHECK,
        ST_FINISH
    } fir_state_e;

    localparam int FIR_NUM_COEF = 33;
    localparam logic [7:0] FIR_TESTVEC_ADR = 8'h1E;

    localparam int FIR_ADR_W = 8;
    localparam int FIR_DAT_W = 16;
    localparam int FIR_CNT_W = 6;
    localparam int FIR_TMO_W = 8;

endpackage

// File: rtl/fir_wb_rd_timeout.sv
// Loadable down-counter bounding how long a Wishbone read strobe waits for an ack.
module fir_wb_rd_timeout
    import fir_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    // Loading N-1 makes the strobe live for exactly ACK_TIMEOUT cycles.
    localparam logic [FIR_TMO_W-1:0] LOAD_VAL = FIR_TMO_W'(ACK_TIMEOUT - 1);

    logic [FIR_TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/fir_coeff_wb_loader.sv
// Streams coefficients from a valid/ready input into consecutive Wishbone registers.
// Define FIR_LOADER_VERIFY_EN to build readback verify (RD_REQ/CHECK with ack timeout).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; bus idle
// ST_FETCH  | s_coef_ready high, waiting for the next coefficient
// ST_WRITE  | single-cycle posted write of the latched coefficient
// ST_RD_REQ | read strobe to the same address, waiting for ack/err/timeout
// ST_CHECK  | compare readback against the written coefficient
// ST_FINISH | one-cycle done pulse, then back to idle
module fir_coeff_wb_loader
    import fir_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int MAX_COUNT   = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [FIR_ADR_W-1:0] base_adr,
    input  logic [FIR_CNT_W-1:0] count,
    input  logic [FIR_DAT_W-1:0] s_coef_data,
    input  logic                 s_coef_valid,
    output logic                 s_coef_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [FIR_CNT_W-1:0] err_index,
    output logic [FIR_ADR_W-1:0] wb_adr,
    input  logic [FIR_DAT_W-1:0] wb_rd_dat,
    output logic [FIR_DAT_W-1:0] wb_wr_dat,
    output logic                 wb_we,
    output logic [1:0]           wb_sel,
    output logic                 wb_stb,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    output logic                 wb_cyc
);

    fir_state_e state_q, state_d;

    logic [FIR_ADR_W-1:0] base_q, base_d;
    logic [FIR_CNT_W-1:0] count_q, count_d;
    logic [FIR_CNT_W-1:0] idx_q, idx_d;
    logic [FIR_DAT_W-1:0] coef_q, coef_d;
    logic                 error_q, error_d;
    logic [FIR_CNT_W-1:0] err_index_q, err_index_d;
    logic                 last_coef;

    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [1:0]           sel_q, sel_d;
    logic [FIR_ADR_W-1:0] adr_q, adr_d;
    logic [FIR_DAT_W-1:0] wr_dat_q, wr_dat_d;

    assign last_coef = (FIR_CNT_W'(idx_q + 1'b1) == count_q);

`ifdef FIR_LOADER_VERIFY_EN
    logic [FIR_DAT_W-1:0] rd_dat_q, rd_dat_d;
    logic                 tmo_load;
    logic                 tmo_expired;

    assign tmo_load = (state_d == ST_RD_REQ) && (state_q != ST_RD_REQ);

    fir_wb_rd_timeout #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_rd_timeout (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (tmo_load),
        .en_i     (state_q == ST_RD_REQ),
        .expired_o(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end
`else
    logic unused_verify;
    assign unused_verify = ^{wb_rd_dat, wb_ack, wb_err, 8'(ACK_TIMEOUT)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            coef_q      <= '0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 2'b00;
            adr_q       <= '0;
            wr_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            coef_q      <= coef_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wr_dat_q    <= wr_dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        coef_d      = coef_q;
        error_d     = error_q;
        err_index_d = err_index_q;
`ifdef FIR_LOADER_VERIFY_EN
        rd_dat_d    = rd_dat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base_adr;
                    count_d     = count;
                    idx_d       = '0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    if (count == '0) begin
                        state_d = ST_FINISH;
                    end else if (int'(count) > MAX_COUNT) begin
                        error_d = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (s_coef_valid && ready_q) begin
                    coef_d  = s_coef_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifdef FIR_LOADER_VERIFY_EN
                state_d = ST_RD_REQ;
`else
                if (last_coef) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = FIR_CNT_W'(idx_q + 1'b1);
                    state_d = ST_FETCH;
                end
`endif
            end
`ifdef FIR_LOADER_VERIFY_EN
            ST_RD_REQ: begin
                if (wb_err || (tmo_expired && !wb_ack)) begin
                    error_d     = 1'b1;
                    err_index_d = idx_q;
                    state_d     = ST_FINISH;
                end else if (wb_ack) begin
                    rd_dat_d = wb_rd_dat;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rd_dat_q != coef_q) begin
                    error_d     = 1'b1;
                    err_index_d = idx_q;
                    state_d     = ST_FINISH;
                end else if (last_coef) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = FIR_CNT_W'(idx_q + 1'b1);
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        ready_d  = (state_d == ST_FETCH);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_FINISH);
        cyc_d    = (state_d == ST_WRITE) || (state_d == ST_RD_REQ);
        stb_d    = cyc_d;
        we_d     = (state_d == ST_WRITE);
        sel_d    = cyc_d ? 2'b11 : 2'b00;
        adr_d    = adr_q;
        wr_dat_d = wr_dat_q;
        if (state_d == ST_WRITE) begin
            adr_d    = base_q + FIR_ADR_W'(idx_q);
            wr_dat_d = coef_d;
        end
    end

    assign s_coef_ready = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_index    = err_index_q;
    assign wb_adr       = adr_q;
    assign wb_wr_dat    = wr_dat_q;
    assign wb_we        = we_q;
    assign wb_sel       = sel_q;
    assign wb_stb       = stb_q;
    assign wb_cyc       = cyc_q;

endmodule

// File: tb/tb_fir_coeff_wb_loader.sv
// Scoreboard bench for fir_coeff_wb_loader; verify-path checks build when FIR_LOADER_VERIFY_EN is defined.
module tb_fir_coeff_wb_loader;

    localparam int ACK_TIMEOUT = 15;
    localparam int MAX_COUNT   = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_adr;
    logic [5:0]  count;
    logic [15:0] s_coef_data;
    logic        s_coef_valid;
    logic        s_coef_ready;
    logic        busy, done, error;
    logic [5:0]  err_index;
    logic [7:0]  wb_adr;
    logic [15:0] wb_rd_dat;
    logic [15:0] wb_wr_dat;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic        wb_stb;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_cyc;

    always #5 clk = ~clk;

    fir_coeff_wb_loader #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MAX_COUNT  (MAX_COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_adr    (base_adr),
        .count       (count),
        .s_coef_data (s_coef_data),
        .s_coef_valid(s_coef_valid),
        .s_coef_ready(s_coef_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_index   (err_index),
        .wb_adr      (wb_adr),
        .wb_rd_dat   (wb_rd_dat),
        .wb_wr_dat   (wb_wr_dat),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_stb      (wb_stb),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .wb_cyc      (wb_cyc)
    );

    typedef struct packed {
        logic [7:0]  adr;
        logic [15:0] dat;
    } wr_t;

    typedef struct packed {
        logic       err;
        logic [5:0] idx;
    } done_t;

    wr_t         exp_wr_q[$];
    done_t       exp_done_q[$];
    logic [15:0] src_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_stb_cycles = 0;
    logic [7:0] last_wr_adr = 8'h00;

    int slave_bad_adr = -1;
    bit slave_noack   = 1'b0;
    logic [15:0] mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-file slave: writes land in mem, reads ack one cycle after the strobe.
    always @(posedge clk) begin
        if (wb_stb && wb_we) mem[wb_adr] <= wb_wr_dat;
        wb_ack    <= wb_stb && !wb_we && !wb_ack && !slave_noack;
        wb_rd_dat <= (int'(wb_adr) == slave_bad_adr) ? 16'h1234 : mem[wb_adr];
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write or a done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_stb && wb_we) begin
                if (exp_wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: adr 0x%0h data 0x%0h, none expected", wb_adr, wb_wr_dat);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    check("wr_adr", 32'(wb_adr), 32'(w.adr));
                    check("wr_dat", 32'(wb_wr_dat), 32'(w.dat));
                    check("wr_sel", 32'(wb_sel), 32'd3);
                    check("wr_cyc", 32'(wb_cyc), 32'd1);
                end
                last_wr_adr = wb_adr;
            end
            if (wb_stb && !wb_we) begin
                rd_stb_cycles++;
                check("rd_adr", 32'(wb_adr), 32'(last_wr_adr));
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: error %0d err_index %0d, none expected", error, err_index);
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    check("done_error", 32'(error), 32'(d.err));
                    if (d.err) check("done_err_index", 32'(err_index), 32'(d.idx));
                end
            end
        end
    end

    // Reference: what a load of cnt coefficients should put on the bus and report.
    task automatic model_load(input logic [7:0] base, input int cnt, input logic [15:0] data[$]);
        done_t d;
        wr_t   w;
        d.err = 1'b0;
        d.idx = '0;
        if (cnt > MAX_COUNT) begin
            d.err = 1'b1;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                w.adr = base + 8'(i);
                w.dat = data[i];
                exp_wr_q.push_back(w);
`ifdef FIR_LOADER_VERIFY_EN
                if (slave_noack || ((int'(w.adr) == slave_bad_adr) && (data[i] != 16'h1234))) begin
                    d.err = 1'b1;
                    d.idx = 6'(i);
                    break;
                end
`endif
            end
        end
        exp_done_q.push_back(d);
    endtask

    task automatic run_load(input logic [7:0] base, input int cnt, input logic [15:0] data[$],
                            input bit gap, input bit chk_lat);
        int  k;
        int  done_k;
        bit  got_done;
        bit  acc;
        int  per;
`ifdef FIR_LOADER_VERIFY_EN
        per = 5;
`else
        per = 2;
`endif
        model_load(base, cnt, data);
        src_q = data;
        rd_stb_cycles = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        base_adr = base;
        count    = 6'(cnt);
        @(posedge clk); #1;
        start    = 1'b0;
        k = 0; done_k = -1; got_done = 1'b0;
        while (!got_done && k < 2000) begin
            s_coef_valid = (!gap || (k % 2 == 0)) && (src_q.size() > 0);
            s_coef_data  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
            @(negedge clk);
            acc = s_coef_valid && s_coef_ready;
            if (done) begin
                got_done = 1'b1;
                done_k   = k;
            end
            @(posedge clk); #1;
            if (acc) void'(src_q.pop_front());
            k++;
        end
        s_coef_valid = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
        if (chk_lat) check("done_latency", 32'(done_k), (cnt > MAX_COUNT) ? 32'd0 : 32'(per * cnt));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("cyc_after_done", 32'(wb_cyc), 32'd0);
        check("writes_outstanding", 32'(exp_wr_q.size()), 32'd0);
        src_q.delete();
    endtask

    initial begin
        logic [15:0] d[$];
        int          nwr;
        int          k;
        bit          acc;
        int          cnt;
        wr_t         w;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b1; start = 1'b0; base_adr = '0; count = '0;
        s_coef_data = '0; s_coef_valid = 1'b0; wb_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(s_coef_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);
        check("rst_bus", 32'({wb_cyc, wb_stb, wb_we, wb_sel}), 32'd0);
        check("rst_adr_dat", 32'({wb_adr, wb_wr_dat}), 32'd0);
        rst = 1'b0;

        d = '{16'h0001, 16'h0002, 16'hFFFF};
        run_load(8'h00, 3, d, 1'b0, 1'b1);

        d.delete();
        run_load(8'h10, 0, d, 1'b0, 1'b1);
        check("count0_no_reads", 32'(rd_stb_cycles), 32'd0);
        run_load(8'h20, 40, d, 1'b0, 1'b1);
        check("count40_no_reads", 32'(rd_stb_cycles), 32'd0);
        check("count40_error", 32'(error), 32'd1);

        d.delete();
        for (int i = 0; i < MAX_COUNT; i++) d.push_back(16'($urandom));
        run_load(8'hE0, MAX_COUNT, d, 1'b0, 1'b1);
        run_load(8'h40, MAX_COUNT + 1, d, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            d.delete();
            cnt = (t == 5) ? 63 : int'($urandom_range(1, MAX_COUNT));
            for (int i = 0; i < cnt; i++) d.push_back(16'($urandom));
            run_load(8'($urandom), cnt, d, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef FIR_LOADER_VERIFY_EN
        d.delete();
        for (int i = 0; i < 33; i++) d.push_back(16'(i * 16'h0101));
        run_load(8'h00, 33, d, 1'b0, 1'b1);
        check("verify_all_ok", 32'(error), 32'd0);

        slave_bad_adr = 5;
        run_load(8'h00, 33, d, 1'b0, 1'b0);
        check("corrupt_err_index", 32'(err_index), 32'd5);
        slave_bad_adr = -1;

        slave_noack = 1'b1;
        run_load(8'h00, 3, d, 1'b0, 1'b0);
        check("noack_strobe_cycles", 32'(rd_stb_cycles), 32'(ACK_TIMEOUT));
        check("noack_err_index", 32'(err_index), 32'd0);
        slave_noack = 1'b0;
`endif

        // Reset in the middle of a load that wraps past 0xFF.
        src_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        w.adr = 8'hFE; w.dat = 16'hAAAA; exp_wr_q.push_back(w);
        w.adr = 8'hFF; w.dat = 16'hBBBB; exp_wr_q.push_back(w);
        @(posedge clk); #1;
        start = 1'b1; base_adr = 8'hFE; count = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        nwr = 0; k = 0;
        while (nwr < 2 && k < 200) begin
            s_coef_valid = (k % 2 == 0) && (src_q.size() > 0);
            s_coef_data  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
            @(negedge clk);
            acc = s_coef_valid && s_coef_ready;
            if (wb_stb && wb_we) nwr++;
            @(posedge clk); #1;
            if (acc) void'(src_q.pop_front());
            k++;
        end
        check("rst_test_writes", 32'(nwr), 32'd2);
        rst = 1'b1;
        s_coef_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bus", 32'({wb_cyc, wb_stb}), 32'd0);
        repeat (6) @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_writes_left", 32'(exp_wr_q.size()), 32'd0);
        src_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
